// File: rtl/mips_io_pkg.sv
// Shared register-map constants and the STATUS word layout for the MIPS port-bus I/O responder.
package mips_io_pkg;

  localparam int IO_DATA_OUT = 0;
  localparam int IO_STATUS   = 1;
  localparam int IO_IN       = 2;
  localparam int IO_CTRL     = 3;

  localparam int STATUS_EMPTY_BIT      = 0;
  localparam int STATUS_FULL_BIT       = 1;
  localparam int STATUS_IN_CHANGED_BIT = 2;
  localparam int STATUS_OVERFLOW_BIT   = 3;
  localparam int STATUS_COUNT_LSB      = 8;

  typedef struct packed {
    logic [7:0] count;
    logic [3:0] rsvd;
    logic       overflow;
    logic       in_changed;
    logic       full;
    logic       empty;
  } io_status_t;

endpackage

// File: rtl/io_port_fifo.sv
// Show-ahead synchronous FIFO for the output path; dout reads 0 while empty.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module io_port_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_WIDTH-1:0]        din,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [AW:0]           count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign count   = count_reg;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mips_io_port.sv
// Memory-mapped I/O port: buffered store path to a valid/ready consumer, synchronised input pins for loads.
// Optional irq output and CTRL register are built when MIPS_IO_PORT_IRQ_EN is defined.
module mips_io_port
  import mips_io_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IN_WIDTH   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] proc_addr,
  input  logic                  proc_wr_en,
  input  logic [DATA_WIDTH-1:0] proc_wdata,
  input  logic                  proc_rd_en,
  output logic [DATA_WIDTH-1:0] proc_rdata,
  input  logic [IN_WIDTH-1:0]   ext_in,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef MIPS_IO_PORT_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0]       fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;

  logic [IN_WIDTH-1:0] sync1_reg;
  logic [IN_WIDTH-1:0] in_sync_reg;
  logic [IN_WIDTH-1:0] in_prev_reg;
  logic                overflow_reg;
  logic                overflow_next;
  logic                in_changed_reg;
  logic                in_changed_next;

  logic                sel_data_out;
  logic                sel_status;
  logic                sel_in;
  logic                change_set;
  logic                overflow_set;
  logic                overflow_clear;
  logic                in_clear;
  io_status_t          status;

  assign sel_data_out = (proc_addr == ADDR_WIDTH'(IO_DATA_OUT));
  assign sel_status   = (proc_addr == ADDR_WIDTH'(IO_STATUS));
  assign sel_in       = (proc_addr == ADDR_WIDTH'(IO_IN));

  assign fifo_push = proc_wr_en & sel_data_out;
  assign fifo_pop  = ~fifo_empty & out_ready;
  assign out_valid = ~fifo_empty;

  io_port_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (proc_wdata),
    .dout  (out_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg   <= '0;
      in_sync_reg <= '0;
      in_prev_reg <= '0;
    end else begin
      sync1_reg   <= ext_in;
      in_sync_reg <= sync1_reg;
      in_prev_reg <= in_sync_reg;
    end
  end

  // Sticky flags: a fresh set always beats a clear arriving in the same cycle.
  assign change_set     = (in_sync_reg != in_prev_reg);
  assign in_clear       = proc_rd_en & sel_in;
  assign overflow_set   = fifo_push & fifo_full & ~fifo_pop;
  assign overflow_clear = proc_wr_en & sel_status & proc_wdata[STATUS_OVERFLOW_BIT];

  always_comb begin
    overflow_next   = overflow_reg;
    in_changed_next = in_changed_reg;
    if (overflow_clear) overflow_next = 1'b0;
    if (overflow_set)   overflow_next = 1'b1;
    if (in_clear)       in_changed_next = 1'b0;
    if (change_set)     in_changed_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_reg   <= 1'b0;
      in_changed_reg <= 1'b0;
    end else begin
      overflow_reg   <= overflow_next;
      in_changed_reg <= in_changed_next;
    end
  end

`ifdef MIPS_IO_PORT_IRQ_EN
  logic sel_ctrl;
  logic irq_en_reg;

  assign sel_ctrl = (proc_addr == ADDR_WIDTH'(IO_CTRL));
  assign irq      = irq_en_reg & in_changed_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_en_reg <= 1'b0;
    end else if (proc_wr_en && sel_ctrl) begin
      irq_en_reg <= proc_wdata[0];
    end
  end
`endif

  always_comb begin
    status            = '0;
    status.count      = 8'(fifo_count);
    status.overflow   = overflow_reg;
    status.in_changed = in_changed_reg;
    status.full       = fifo_full;
    status.empty      = fifo_empty;
  end

  always_comb begin
    proc_rdata = '0;
    if (proc_rd_en) begin
      if (sel_status) begin
        proc_rdata = DATA_WIDTH'(status);
      end else if (sel_in) begin
        proc_rdata = DATA_WIDTH'(in_sync_reg);
      end
`ifdef MIPS_IO_PORT_IRQ_EN
      else if (sel_ctrl) begin
        proc_rdata = DATA_WIDTH'(irq_en_reg);
      end
`endif
    end
  end

endmodule

// File: tb/tb_mips_io_port.sv
// Bench for mips_io_port: directed scenarios plus randomized bus/consumer/pin traffic against a queue-based model.
`timescale 1ns/1ps
module tb_mips_io_port;

  localparam int DEPTH = 4;

  logic        clk        = 1'b0;
  logic        rst        = 1'b0;
  logic [3:0]  proc_addr  = '0;
  logic        proc_wr_en = 1'b0;
  logic [31:0] proc_wdata = '0;
  logic        proc_rd_en = 1'b0;
  logic [31:0] proc_rdata;
  logic [7:0]  ext_in     = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready  = 1'b0;
`ifdef MIPS_IO_PORT_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  mips_io_port dut (
    .clk        (clk),
    .rst        (rst),
    .proc_addr  (proc_addr),
    .proc_wr_en (proc_wr_en),
    .proc_wdata (proc_wdata),
    .proc_rd_en (proc_rd_en),
    .proc_rdata (proc_rdata),
    .ext_in     (ext_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef MIPS_IO_PORT_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  int checks_total  = 0;
  int checks_passed = 0;
  int cyc           = 0;

  // Reference model: FIFO contents as a queue, flags as bits, pin samples taken at each edge.
  logic [31:0] mq [$];
  logic        m_ovf;
  logic        m_chg;
  logic        m_irq_en;
  logic [7:0]  smp [3];
  logic [31:0] t4_exp [4] = '{32'h11, 32'h12, 32'h13, 32'h55};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks_total++;
    if (got === want) checks_passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf    = 1'b0;
    m_chg    = 1'b0;
    m_irq_en = 1'b0;
    for (int i = 0; i < 3; i++) smp[i] = '0;
  endtask

  function automatic logic [31:0] exp_status();
    int n = mq.size();
    return (32'(n) << 8) | (m_ovf ? 32'h8 : 32'h0) | (m_chg ? 32'h4 : 32'h0)
         | ((n == DEPTH) ? 32'h2 : 32'h0) | ((n == 0) ? 32'h1 : 32'h0);
  endfunction

  // smp[1] is the pin value two edges old, i.e. what the processor sees through the synchroniser.
  function automatic logic [31:0] exp_rdata();
    if (!proc_rd_en) return 32'h0;
    case (proc_addr)
      4'd1:    return exp_status();
      4'd2:    return {24'h0, smp[1]};
`ifdef MIPS_IO_PORT_IRQ_EN
      4'd3:    return {31'h0, m_irq_en};
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic set_bus(input logic wr, input logic rd, input logic [3:0] addr, input logic [31:0] data);
    proc_wr_en = wr;
    proc_rd_en = rd;
    proc_addr  = addr;
    proc_wdata = data;
  endtask

  // One clock: compare outputs against the model mid-cycle, then advance the model on the edge.
  task automatic step();
    bit pop;
    bit push;
    bit dropped;
    @(negedge clk);
    check_eq("out_valid", 32'(out_valid), (mq.size() != 0) ? 32'd1 : 32'd0);
    check_eq("out_data", out_data, (mq.size() != 0) ? mq[0] : 32'h0);
    check_eq("proc_rdata", proc_rdata, exp_rdata());
`ifdef MIPS_IO_PORT_IRQ_EN
    check_eq("irq", 32'(irq), (m_irq_en && m_chg) ? 32'd1 : 32'd0);
`endif
    if (proc_wr_en || proc_rd_en)
      $display("cyc %0d addr=%0d wr=%0b wdata=%08h rd=%0b rdata=%08h ready=%0b",
               cyc, proc_addr, proc_wr_en, proc_wdata, proc_rd_en, proc_rdata, out_ready);
    @(posedge clk);
    pop     = (mq.size() != 0) && out_ready;
    push    = proc_wr_en && (proc_addr == 4'd0);
    dropped = push && (mq.size() == DEPTH) && !pop;
    if (pop) void'(mq.pop_front());
    if (push && !dropped) mq.push_back(proc_wdata);
    if (proc_wr_en && proc_addr == 4'd1 && proc_wdata[3]) m_ovf = 1'b0;
    if (dropped) m_ovf = 1'b1;
    if (proc_rd_en && proc_addr == 4'd2) m_chg = 1'b0;
    if (smp[1] != smp[2]) m_chg = 1'b1;
`ifdef MIPS_IO_PORT_IRQ_EN
    if (proc_wr_en && proc_addr == 4'd3) m_irq_en = proc_wdata[0];
`endif
    smp[2] = smp[1];
    smp[1] = smp[0];
    smp[0] = ext_in;
    cyc++;
    #1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", out_data, 32'h0);
    rst = 1'b1;

    // Idle status after reset
    set_bus(1'b0, 1'b1, 4'd1, 32'h0); #1;
    check_eq("t1_status", proc_rdata, 32'h0000_0001);
    step();

    // Single word through the FIFO
    set_bus(1'b1, 1'b0, 4'd0, 32'hDEAD_BEEF); step();
    set_bus(1'b0, 1'b1, 4'd1, 32'h0); #1;
    check_eq("t2_valid", 32'(out_valid), 32'd1);
    check_eq("t2_data", out_data, 32'hDEAD_BEEF);
    check_eq("t2_status", proc_rdata, 32'h0000_0100);
    step();
    out_ready = 1'b1;
    set_bus(1'b0, 1'b0, 4'd0, 32'h0); step();
    out_ready = 1'b0;
    set_bus(1'b0, 1'b1, 4'd1, 32'h0); #1;
    check_eq("t2_empty", proc_rdata, 32'h0000_0001);
    step();

    // Overflow on the fifth write, in-order drain, W1C
    for (int i = 1; i <= 5; i++) begin
      set_bus(1'b1, 1'b0, 4'd0, 32'(i)); step();
    end
    set_bus(1'b0, 1'b1, 4'd1, 32'h0); #1;
    check_eq("t3_status", proc_rdata, 32'h0000_040A);
    step();
    set_bus(1'b0, 1'b0, 4'd0, 32'h0);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check_eq("t3_drain", out_data, 32'(i));
      step();
    end
    out_ready = 1'b0;
    set_bus(1'b1, 1'b0, 4'd1, 32'h8); step();
    set_bus(1'b0, 1'b1, 4'd1, 32'h0); #1;
    check_eq("t3_w1c", proc_rdata, 32'h0000_0001);
    step();

    // Push and pop together while full
    for (int i = 0; i < 4; i++) begin
      set_bus(1'b1, 1'b0, 4'd0, 32'h10 + 32'(i)); step();
    end
    out_ready = 1'b1;
    set_bus(1'b1, 1'b0, 4'd0, 32'h55); step();
    out_ready = 1'b0;
    set_bus(1'b0, 1'b1, 4'd1, 32'h0); #1;
    check_eq("t4_status", proc_rdata, 32'h0000_0402);
    step();
    set_bus(1'b0, 1'b0, 4'd0, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("t4_drain", out_data, t4_exp[i]);
      step();
    end
    out_ready = 1'b0;

    // Input change latency and read-clear
    ext_in = 8'h03;
    set_bus(1'b0, 1'b1, 4'd1, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check_eq("t5_chg_lat", proc_rdata & 32'h4, (k == 3) ? 32'h4 : 32'h0);
    end
    set_bus(1'b0, 1'b1, 4'd2, 32'h0); #1;
    check_eq("t5_in", proc_rdata, 32'h0000_0003);
    step();
    set_bus(1'b0, 1'b1, 4'd1, 32'h0); #1;
    check_eq("t5_clr", proc_rdata & 32'h4, 32'h0);
    step();

`ifdef MIPS_IO_PORT_IRQ_EN
    set_bus(1'b1, 1'b0, 4'd3, 32'h1); step();
    ext_in = 8'h07;
    set_bus(1'b0, 1'b0, 4'd0, 32'h0);
    repeat (3) step();
    check_eq("t6_irq_set", 32'(irq), 32'd1);
    set_bus(1'b0, 1'b1, 4'd2, 32'h0); step();
    check_eq("t6_irq_clr", 32'(irq), 32'd0);
    set_bus(1'b1, 1'b0, 4'd3, 32'h0); step();
    ext_in = 8'h00;
    set_bus(1'b0, 1'b0, 4'd0, 32'h0);
    repeat (4) step();
    check_eq("t6_irq_off", 32'(irq), 32'd0);
`endif

    // Randomized traffic with an asynchronous reset in the middle
    for (int c = 0; c < 800; c++) begin
      if (c == 400) begin
        rst = 1'b0;
        #2;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_data", out_data, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
      end
      proc_wr_en = ($urandom_range(0, 9) < 5);
      proc_rd_en = ($urandom_range(0, 1) == 1);
      proc_addr  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      proc_wdata = $urandom;
      out_ready  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) ext_in = 8'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
